// File: rtl/acl_hdr_parser_if.sv
// Ingress beat stream (32-bit, no backpressure) consumed by acl_hdr_parser.
interface acl_hdr_parser_if;
    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;

    modport master (output tvalid, output tdata, output tlast);
    modport slave  (input  tvalid, input  tdata, input  tlast);
endinterface

// File: rtl/acl_hdr_parser.sv
// Ethernet/IPv4/L4 header field extractor for the ACL match stage.
// Optional ACL_HDR_STATS_EN adds saturating frame/runt/TCP counters.
module acl_hdr_parser #(
    parameter int WORD_CNT_W = 16,
    parameter int HDR_BEATS  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    acl_hdr_parser_if.slave       rxd,
    output logic [47:0]           o_dst_mac,
    output logic [47:0]           o_src_mac,
    output logic [15:0]           o_ethertype,
    output logic [7:0]            o_ip_proto,
    output logic [31:0]           o_src_ip,
    output logic [31:0]           o_dst_ip,
    output logic [15:0]           o_src_port,
    output logic [15:0]           o_dst_port,
    output logic                  o_is_ipv4,
    output logic                  o_is_tcp,
    output logic                  o_hdr_valid,
    output logic                  o_frame_done,
    output logic [WORD_CNT_W-1:0] o_frame_words,
    output logic                  o_runt
`ifdef ACL_HDR_STATS_EN
    ,
    output logic [31:0]           o_stat_frames,
    output logic [31:0]           o_stat_runts,
    output logic [31:0]           o_stat_tcp
`endif
);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    localparam logic [WORD_CNT_W-1:0] LAST_HDR = WORD_CNT_W'(HDR_BEATS - 1);

    state_t                state, state_nxt;
    logic [WORD_CNT_W-1:0] cnt;
    logic [WORD_CNT_W-1:0] idx;
    logic [WORD_CNT_W-1:0] idx_inc;
    logic [3:0]            beat_sel;
    logic                  hdr_phase;
    logic                  hdr_done;
    logic                  last_beat;

    logic [47:0] sh_dst_mac;
    logic [47:0] sh_src_mac;
    logic [15:0] sh_ethertype;
    logic [7:0]  sh_ver_ihl;
    logic [7:0]  sh_proto;
    logic [31:0] sh_src_ip;
    logic [31:0] sh_dst_ip;
    logic [15:0] sh_src_port;
    logic        nxt_is_ipv4;
    logic        nxt_is_tcp;

    // In IDLE the incoming beat is always index 0, regardless of stale cnt.
    assign idx       = (state == IDLE) ? '0 : cnt;
    assign idx_inc   = (&idx) ? idx : idx + 1'b1;
    assign beat_sel  = idx[3:0];
    assign hdr_phase = rxd.tvalid && (state != PAYLOAD);
    assign hdr_done  = rxd.tvalid && (state == HDR) && (idx == LAST_HDR);
    assign last_beat = rxd.tvalid && rxd.tlast;

    assign nxt_is_ipv4 = (sh_ethertype == 16'h0800) && (sh_ver_ihl == 8'h45);
    assign nxt_is_tcp  = nxt_is_ipv4 && (sh_proto == 8'h06);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (rxd.tvalid) begin
            case (state)
                IDLE:    if (!rxd.tlast) state_nxt = HDR;
                HDR: begin
                    if (rxd.tlast)            state_nxt = IDLE;
                    else if (idx == LAST_HDR) state_nxt = PAYLOAD;
                end
                PAYLOAD: if (rxd.tlast) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (rxd.tvalid) begin
            cnt <= rxd.tlast ? '0 : idx_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_dst_mac   <= '0;
            sh_src_mac   <= '0;
            sh_ethertype <= '0;
            sh_ver_ihl   <= '0;
            sh_proto     <= '0;
            sh_src_ip    <= '0;
            sh_dst_ip    <= '0;
            sh_src_port  <= '0;
        end else if (hdr_phase) begin
            case (beat_sel)
                4'd0: sh_dst_mac[47:16] <= rxd.tdata;
                4'd1: begin
                    sh_dst_mac[15:0]  <= rxd.tdata[31:16];
                    sh_src_mac[47:32] <= rxd.tdata[15:0];
                end
                4'd2: sh_src_mac[31:0] <= rxd.tdata;
                4'd3: begin
                    sh_ethertype <= rxd.tdata[31:16];
                    sh_ver_ihl   <= rxd.tdata[15:8];
                end
                4'd5: sh_proto <= rxd.tdata[7:0];
                4'd6: sh_src_ip[31:16] <= rxd.tdata[15:0];
                4'd7: begin
                    sh_src_ip[15:0]  <= rxd.tdata[31:16];
                    sh_dst_ip[31:16] <= rxd.tdata[15:0];
                end
                4'd8: begin
                    sh_dst_ip[15:0] <= rxd.tdata[31:16];
                    sh_src_port     <= rxd.tdata[15:0];
                end
                default: ;
            endcase
        end
    end

    // Beat 9 carries dst_port, so it bypasses the shadow and loads straight out.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_dst_mac   <= '0;
            o_src_mac   <= '0;
            o_ethertype <= '0;
            o_ip_proto  <= '0;
            o_src_ip    <= '0;
            o_dst_ip    <= '0;
            o_src_port  <= '0;
            o_dst_port  <= '0;
            o_is_ipv4   <= 1'b0;
            o_is_tcp    <= 1'b0;
        end else if (hdr_done) begin
            o_dst_mac   <= sh_dst_mac;
            o_src_mac   <= sh_src_mac;
            o_ethertype <= sh_ethertype;
            o_ip_proto  <= sh_proto;
            o_src_ip    <= sh_src_ip;
            o_dst_ip    <= sh_dst_ip;
            o_src_port  <= sh_src_port;
            o_dst_port  <= rxd.tdata[31:16];
            o_is_ipv4   <= nxt_is_ipv4;
            o_is_tcp    <= nxt_is_tcp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_hdr_valid   <= 1'b0;
            o_frame_done  <= 1'b0;
            o_runt        <= 1'b0;
            o_frame_words <= '0;
        end else begin
            o_hdr_valid  <= hdr_done;
            o_frame_done <= last_beat;
            o_runt       <= last_beat && (state != PAYLOAD) && (idx < LAST_HDR);
            if (last_beat) o_frame_words <= idx_inc;
        end
    end

`ifdef ACL_HDR_STATS_EN
    // Counters advance on the same edge that raises the matching strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_stat_frames <= '0;
            o_stat_runts  <= '0;
            o_stat_tcp    <= '0;
        end else begin
            if (last_beat && !(&o_stat_frames))
                o_stat_frames <= o_stat_frames + 32'd1;
            if (last_beat && (state != PAYLOAD) && (idx < LAST_HDR) && !(&o_stat_runts))
                o_stat_runts <= o_stat_runts + 32'd1;
            if (hdr_done && nxt_is_tcp && !(&o_stat_tcp))
                o_stat_tcp <= o_stat_tcp + 32'd1;
        end
    end
`endif

endmodule
